// File: rtl/reg_bus_writer_if.sv
// Request/response and register-bank signals between reg_bus_writer and its environment.
// The slave side is the sequencer; the master side issues requests and models the bus.
interface reg_bus_writer_if;
    logic       req;
    logic       we;
    logic [1:0] sel;
    logic [7:0] wdata;
    logic [7:0] bus_in;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic [7:0] d_out;
    logic       d_oe_n;
    logic [3:0] reg_clk;
    logic [3:0] reg_oe_n;

    modport master (
        output req, we, sel, wdata, bus_in,
        input  busy, done, rdata, d_out, d_oe_n, reg_clk, reg_oe_n
    );

    modport slave (
        input  req, we, sel, wdata, bus_in,
        output busy, done, rdata, d_out, d_oe_n, reg_clk, reg_oe_n
    );
endinterface

// File: rtl/reg_bus_writer.sv
// Sequences single-word writes and reads to four 74574-style registers sharing an 8-bit bus.
// Every output is a flop written by the FSM, so no input reaches an output combinationally.
module reg_bus_writer #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned PULSE_CYCLES  = 1,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    reg_bus_writer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETTLE, TURN, FIN
    } state_t;

    // Counters load "cycles - 1" on entry and leave the phase when they reach zero.
    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] sel_q;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic [7:0] d_out;
    logic       d_oe_n;
    logic [3:0] reg_clk;
    logic [3:0] reg_oe_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            sel_q    <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            d_out    <= 8'h00;
            d_oe_n   <= 1'b1;
            reg_clk  <= 4'b0000;
            reg_oe_n <= 4'b1111;
        end else begin
            // NOTE: non-blocking assignments, so every branch below reads pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        sel_q <= bus.sel;
                        busy  <= 1'b1;
                        if (bus.we) begin
                            state  <= W_SETUP;
                            cnt    <= SETUP_LAST;
                            d_out  <= bus.wdata;
                            d_oe_n <= 1'b0;
                        end else begin
                            state    <= R_SETTLE;
                            cnt      <= SETTLE_LAST;
                            reg_oe_n <= ~(4'b0001 << bus.sel);
                        end
                    end
                end
                W_SETUP: begin
                    if (cnt == 4'd0) begin
                        state   <= W_PULSE;
                        cnt     <= PULSE_LAST;
                        reg_clk <= 4'b0001 << sel_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                W_PULSE: begin
                    if (cnt == 4'd0) begin
                        state   <= W_HOLD;
                        cnt     <= HOLD_LAST;
                        reg_clk <= 4'b0000;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                W_HOLD: begin
                    if (cnt == 4'd0) begin
                        state  <= TURN;
                        d_oe_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                R_SETTLE: begin
                    // Bus has settled for the full window by the last cycle; capture it there.
                    if (cnt == 4'd0) begin
                        state    <= TURN;
                        rdata    <= bus.bus_in;
                        reg_oe_n <= 4'b1111;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                TURN: begin
                    state <= FIN;
                    done  <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.rdata    = rdata;
    assign bus.d_out    = d_out;
    assign bus.d_oe_n   = d_oe_n;
    assign bus.reg_clk  = reg_clk;
    assign bus.reg_oe_n = reg_oe_n;
endmodule

// File: tb/tb_reg_bus_writer.sv
// Self-checking bench: two instances (default and stretched timing) sharing one clock,
// each with a four-register bank model that answers on the bus while its output is enabled.
module tb_reg_bus_writer;
    localparam int P_SETUP[2]  = '{2, 3};
    localparam int P_PULSE[2]  = '{1, 2};
    localparam int P_HOLD[2]   = '{1, 4};
    localparam int P_SETTLE[2] = '{2, 5};

    typedef struct packed {
        logic       req;
        logic       we;
        logic [1:0] sel;
        logic [7:0] wdata;
    } drv_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       d_oe_n;
        logic [3:0] reg_clk;
        logic [3:0] reg_oe_n;
        logic [7:0] d_out;
        logic [7:0] rdata;
    } obs_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       d_oe_n;
        logic [3:0] reg_clk;
        logic [3:0] reg_oe_n;
        logic [7:0] d_out;
        logic       dmask;
    } exp_t;

    typedef struct {
        int         d;
        bit         we;
        logic [1:0] sel;
        logic [7:0] wdata;
        bit         scramble;
        int         exp_lat;
        logic [7:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    drv_t drv[2];
    obs_t obs[2];
    logic [7:0] bus_in_v[2];
    logic [7:0] bank[2][4];
    logic [3:0] clk_prev[2];
    bit   bank_ready = 1'b0;
    bit   mon_en = 1'b0;
    int   inv_fail = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] model_regs[2][4];

    always #5 clk = ~clk;

    reg_bus_writer_if bus0 ();
    reg_bus_writer_if bus1 ();

    reg_bus_writer dut0 (.clk(clk), .reset(reset), .bus(bus0));

    reg_bus_writer #(
        .SETUP_CYCLES(P_SETUP[1]), .PULSE_CYCLES(P_PULSE[1]),
        .HOLD_CYCLES(P_HOLD[1]), .SETTLE_CYCLES(P_SETTLE[1])
    ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    assign bus0.req = drv[0].req;
    assign bus0.we = drv[0].we;
    assign bus0.sel = drv[0].sel;
    assign bus0.wdata = drv[0].wdata;
    assign bus0.bus_in = bus_in_v[0];
    assign bus1.req = drv[1].req;
    assign bus1.we = drv[1].we;
    assign bus1.sel = drv[1].sel;
    assign bus1.wdata = drv[1].wdata;
    assign bus1.bus_in = bus_in_v[1];

    assign obs[0] = {bus0.busy, bus0.done, bus0.d_oe_n, bus0.reg_clk, bus0.reg_oe_n, bus0.d_out, bus0.rdata};
    assign obs[1] = {bus1.busy, bus1.done, bus1.d_oe_n, bus1.reg_clk, bus1.reg_oe_n, bus1.d_out, bus1.rdata};

    // Registers drive the bus only while their output enable is low; otherwise it floats high.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            bus_in_v[d] = 8'hFF;
            for (int i = 0; i < 4; i++)
                if (obs[d].reg_oe_n[i] == 1'b0) bus_in_v[d] = bank[d][i];
        end
    end

    function automatic int inv_bad(input obs_t o);
        int b = 0;
        if (!o.d_oe_n && o.reg_oe_n != 4'hF) b++;
        if ($countones(o.reg_clk) > 1) b++;
        if ($countones(~o.reg_oe_n) > 1) b++;
        return b;
    endfunction

    // Bank latches D on each REG_CLK rising edge; bus invariants are tallied every cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (!bank_ready) bank[d][i] <= 8'h10 + 8'(i);
                else if (obs[d].reg_clk[i] === 1'b1 && clk_prev[d][i] !== 1'b1) bank[d][i] <= obs[d].d_out;
            end
            clk_prev[d] <= obs[d].reg_clk;
        end
        bank_ready <= 1'b1;
        if (mon_en) inv_fail <= inv_fail + inv_bad(obs[0]) + inv_bad(obs[1]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int model_len(input int d, input bit w);
        return w ? P_SETUP[d] + P_PULSE[d] + P_HOLD[d] + 2 : P_SETTLE[d] + 2;
    endfunction

    // Expected outputs k cycles after acceptance, straight from the phase-length arithmetic.
    function automatic exp_t model_cycle(input int d, input bit w, input logic [1:0] s,
                                         input logic [7:0] data, input int k);
        exp_t e;
        int   n = model_len(d, w);
        e = '{busy: 1'b1, done: 1'b0, d_oe_n: 1'b1, reg_clk: 4'h0, reg_oe_n: 4'hF,
              d_out: 8'h00, dmask: 1'b0};
        if (w) begin
            if (k <= P_SETUP[d] + P_PULSE[d] + P_HOLD[d]) begin
                e.d_oe_n = 1'b0;
                e.d_out = data;
                e.dmask = 1'b1;
                if (k > P_SETUP[d] && k <= P_SETUP[d] + P_PULSE[d]) e.reg_clk = 4'b0001 << s;
            end
        end else if (k <= P_SETTLE[d]) begin
            e.reg_oe_n = ~(4'b0001 << s);
        end
        if (k == n) e.done = 1'b1;
        if (k > n) e.busy = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] pack_obs(input obs_t o, input logic dmask);
        return {13'b0, o.busy, o.done, o.d_oe_n, o.reg_clk, o.reg_oe_n, dmask ? o.d_out : 8'h00};
    endfunction

    function automatic logic [31:0] pack_exp(input exp_t e);
        return {13'b0, e.busy, e.done, e.d_oe_n, e.reg_clk, e.reg_oe_n, e.dmask ? e.d_out : 8'h00};
    endfunction

    // Call at a negedge with the target idle; returns at the negedge of the first idle cycle.
    task automatic run_txn(input int d, input bit w, input logic [1:0] s, input logic [7:0] data,
                           input bit scramble, output int lat, output logic [7:0] rd);
        exp_t e;
        drv[d].req = 1'b1;
        drv[d].we = w;
        drv[d].sel = s;
        drv[d].wdata = data;
        lat = 0;
        for (int k = 1; k <= model_len(d, w) + 1; k++) begin
            @(negedge clk);
            e = model_cycle(d, w, s, data, k);
            check($sformatf("dut%0d %s sel%0d cycle%0d", d, w ? "wr" : "rd", s, k),
                  pack_obs(obs[d], e.dmask), pack_exp(e));
            if (obs[d].done === 1'b1 && lat == 0) lat = k;
            if (scramble) begin
                drv[d].req = 1'($urandom_range(0, 1));
                drv[d].we = 1'($urandom_range(0, 1));
                drv[d].sel = 2'($urandom_range(0, 3));
                drv[d].wdata = 8'($urandom);
            end else begin
                drv[d].req = 1'b0;
            end
        end
        drv[d].req = 1'b0;
        rd = obs[d].rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[8];
        int         lat;
        int         n_acc;
        int         gap;
        int         seen;
        logic [7:0] rd;
        bit         is_w;
        bit         last_w;
        bit         prev_busy;
        bit         w;
        int         d;
        logic [1:0] s;
        logic [7:0] data;

        vecs[0] = '{0, 1'b1, 2'd2, 8'hAA, 1'b0, 6, 8'h00};
        vecs[1] = '{0, 1'b0, 2'd2, 8'h00, 1'b0, 4, 8'hAA};
        vecs[2] = '{0, 1'b1, 2'd0, 8'h5A, 1'b1, 6, 8'h00};
        vecs[3] = '{0, 1'b0, 2'd0, 8'h00, 1'b0, 4, 8'h5A};
        vecs[4] = '{0, 1'b0, 2'd1, 8'h00, 1'b0, 4, 8'h11};
        vecs[5] = '{1, 1'b1, 2'd3, 8'h3C, 1'b0, 11, 8'h00};
        vecs[6] = '{1, 1'b0, 2'd3, 8'h00, 1'b0, 7, 8'h3C};
        vecs[7] = '{1, 1'b0, 2'd0, 8'h00, 1'b1, 7, 8'h10};

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) model_regs[i][j] = 8'h10 + 8'(j);

        drv[0] = '0;
        drv[1] = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_values dut%0d", i), {5'b0, obs[i]},
                  {5'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 8'h00, 8'h00});
        reset = 1'b0;
        mon_en = 1'b1;

        // Directed vectors, including the stretched-timing latencies on dut1.
        foreach (vecs[i]) begin
            run_txn(vecs[i].d, vecs[i].we, vecs[i].sel, vecs[i].wdata, vecs[i].scramble, lat, rd);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].we) model_regs[vecs[i].d][vecs[i].sel] = vecs[i].wdata;
            else check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
        end

        // REQ held high with WE toggling: transactions alternate, one idle cycle between them.
        drv[0] = '{req: 1'b1, we: 1'b1, sel: 2'd3, wdata: 8'h77};
        prev_busy = 1'b0;
        last_w = 1'b0;
        gap = 0;
        n_acc = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (obs[0].busy && !prev_busy) begin
                is_w = !obs[0].d_oe_n;
                if (n_acc > 0) begin
                    check($sformatf("b2b alternate #%0d", n_acc), is_w, !last_w);
                    check($sformatf("b2b idle gap #%0d", n_acc), gap, 1);
                end
                last_w = is_w;
                n_acc++;
            end
            gap = obs[0].busy ? 0 : gap + 1;
            prev_busy = obs[0].busy;
            drv[0].we = ~drv[0].we;
        end
        check("b2b accepted >= 6", n_acc >= 6, 1);
        drv[0].req = 1'b0;
        for (int c = 0; c < 20 && obs[0].busy; c++) @(negedge clk);
        check("b2b drained", obs[0].busy, 1'b0);
        @(negedge clk);
        model_regs[0][3] = 8'h77;
        check("b2b last rdata", obs[0].rdata, 8'h77);

        // Random traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            d = $urandom_range(0, 1);
            w = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            data = 8'($urandom);
            run_txn(d, w, s, data, $urandom_range(0, 3) == 0, lat, rd);
            check($sformatf("rand%0d latency", t), lat, model_len(d, w));
            if (w) model_regs[d][s] = data;
            else check($sformatf("rand%0d rdata", t), rd, model_regs[d][s]);
        end

        // Reset wins over a same-cycle request.
        reset = 1'b1;
        drv[0] = '{req: 1'b1, we: 1'b1, sel: 2'd0, wdata: 8'h01};
        @(negedge clk);
        check("reset_priority busy/d_oe_n", {obs[0].busy, obs[0].d_oe_n}, 2'b01);
        reset = 1'b0;
        drv[0].req = 1'b0;
        @(negedge clk);

        // Reset during the write pulse: outputs drop at once and DONE never follows.
        drv[0] = '{req: 1'b1, we: 1'b1, sel: 2'd1, wdata: 8'hC3};
        @(negedge clk);
        drv[0].req = 1'b0;
        repeat (P_SETUP[0]) @(negedge clk);
        check("abort_wr in pulse reg_clk", obs[0].reg_clk, 4'b0010);
        reset = 1'b1;
        @(negedge clk);
        check("abort_wr outputs", {obs[0].reg_clk, obs[0].d_oe_n, obs[0].busy, obs[0].done, obs[0].rdata},
              {4'b0000, 1'b1, 1'b0, 1'b0, 8'h00});
        reset = 1'b0;
        model_regs[0][1] = 8'hC3;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (obs[0].done) seen++;
        end
        check("abort_wr no done", seen, 0);

        // Reset during read settle: RDATA keeps its reset value.
        drv[0] = '{req: 1'b1, we: 1'b0, sel: 2'd2, wdata: 8'h00};
        @(negedge clk);
        drv[0].req = 1'b0;
        check("abort_rd in settle reg_oe_n", obs[0].reg_oe_n, 4'b1011);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (obs[0].done) seen++;
        end
        check("abort_rd no done", seen, 0);
        check("abort_rd rdata/busy/reg_oe_n", {obs[0].rdata, obs[0].busy, obs[0].reg_oe_n},
              {8'h00, 1'b0, 4'hF});

        // The aborted write had already clocked register 1.
        run_txn(0, 1'b0, 2'd1, 8'h00, 1'b0, lat, rd);
        check("post-abort read latency", lat, model_len(0, 1'b0));
        check("post-abort read rdata", rd, model_regs[0][1]);

        @(posedge clk);
        @(negedge clk);
        check("bus invariants violations", inv_fail, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_bus_writer.md
REG_BUS_WRITER -- requirements
Module: reg_bus_writer

Interface
REQ-001 The block SHALL have parameter SETUP_CYCLES, default 2: cycles D_OUT is stable before the REG_CLK rising edge (range 1-15).
REQ-002 The block SHALL have parameter PULSE_CYCLES, default 1: cycles REG_CLK is held high (range 1-15).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 1: cycles D_OUT is held after the REG_CLK falling edge (range 1-15).
REQ-004 The block SHALL have parameter SETTLE_CYCLES, default 2: cycles after a register output is enabled before BUS_IN is sampled (range 1-15).
REQ-005 CLK  input  1  single clock; all state changes on the rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 REQ  input  1  request strobe; accepted only in IDLE.
REQ-008 WE  input  1  1 = write transaction, 0 = read transaction; sampled with REQ.
REQ-009 SEL  input  2  target register index 0-3; sampled with REQ.
REQ-010 WDATA  input  8  write data; sampled with REQ.
REQ-011 BUS_IN  input  8  shared bus value as seen from the registers' Q outputs.
REQ-012 BUSY  output  1  high in every state except IDLE.
REQ-013 DONE  output  1  one-cycle pulse marking transaction completion.
REQ-014 RDATA  output  8  last read result; holds its value until the next read completes.
REQ-015 D_OUT  output  8  data presented to the registers' D inputs.
REQ-016 D_OE_N  output  1  active-low enable of the block's bus driver.
REQ-017 REG_CLK  output  4  one clock line per 74574-style register.
REQ-018 REG_OE_N  output  4  one active-low output enable per register.

Function
REQ-019 The FSM SHALL have the states IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETTLE, TURN and FIN.
REQ-020 In IDLE, when REQ=1, the block SHALL latch WE, SEL and WDATA into internal registers and move to W_SETUP if WE=1, else to R_SETTLE.
REQ-021 All later behaviour SHALL use the latched values; changes to REQ, WE, SEL or WDATA while BUSY=1 SHALL be ignored.
REQ-022 W_SETUP: D_OUT=latched data, D_OE_N=0, all REG_CLK=0, held for exactly SETUP_CYCLES cycles, then W_PULSE.
REQ-023 W_PULSE: REG_CLK[sel]=1 and the other REG_CLK bits=0, D_OUT and D_OE_N unchanged, held for exactly PULSE_CYCLES cycles, then W_HOLD.
REQ-024 W_HOLD: all REG_CLK=0, D_OUT and D_OE_N unchanged, held for exactly HOLD_CYCLES cycles, then TURN.
REQ-025 R_SETTLE: REG_OE_N[sel]=0, the other REG_OE_N bits=1, D_OE_N=1, held for exactly SETTLE_CYCLES cycles.
REQ-026 On the last R_SETTLE cycle, RDATA SHALL load BUS_IN, and the FSM SHALL then move to TURN.
REQ-027 TURN: D_OE_N=1 and all REG_OE_N=1 for exactly one cycle (bus turnaround), then FIN.
REQ-028 FIN: DONE=1 for exactly one cycle, then IDLE.
REQ-029 A REQ present during FIN SHALL be ignored.
REQ-030 Write latency SHALL be SETUP_CYCLES+PULSE_CYCLES+HOLD_CYCLES+2 cycles from the REQ edge to the DONE edge.
REQ-031 Read latency SHALL be SETTLE_CYCLES+2 cycles from the REQ edge to the DONE edge.
REQ-032 Invariant, every cycle: D_OE_N=0 and any REG_OE_N bit=0 SHALL never be true together.
REQ-033 Invariant, every cycle: at most one REG_CLK bit is high and at most one REG_OE_N bit is low.
REQ-034 Outside R_SETTLE, all REG_OE_N bits SHALL be 1.
REQ-035 Outside W_SETUP, W_PULSE and W_HOLD, D_OE_N SHALL be 1.
REQ-036 Phase counters SHALL be 4 bits wide, reload on every state entry, and SHALL never wrap within a phase.
REQ-037 Back-to-back transactions: a REQ asserted in the cycle after FIN SHALL be accepted.
REQ-038 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-039 RESET=1 at a rising CLK edge SHALL force IDLE from any state, including mid-transaction.
REQ-040 After reset: BUSY=0, DONE=0, RDATA=8'h00, D_OUT=8'h00, D_OE_N=1, REG_CLK=4'b0000, REG_OE_N=4'b1111.
REQ-041 RESET SHALL take priority over REQ in the same cycle.
REQ-042 A transaction aborted by reset SHALL produce no DONE pulse and SHALL leave RDATA unchanged from its reset value.

Verification
REQ-043 Write, default parameters, SEL=2, WDATA=8'hAA: D_OUT=AA with D_OE_N=0 for 2 cycles, then REG_CLK=4'b0100 for 1 cycle, then 1 hold cycle, then TURN, then DONE; total 6 cycles.
REQ-044 Read after REQ-043, SEL=2, bench model drives BUS_IN=8'hAA only while REG_OE_N[2]=0, otherwise 8'hFF: REG_OE_N=4'b1011 for 2 cycles, RDATA=8'hAA at DONE, 4 cycles.
REQ-045 Reset asserted during W_PULSE of a write to SEL=1: the next cycle shows REG_CLK=0, D_OE_N=1, BUSY=0, and no DONE pulse ever follows.
REQ-046 REQ held high continuously with WE toggling each cycle: writes and reads alternate, each REQ is accepted only in IDLE, and the contention invariant (REQ-032) holds on every cycle.
REQ-047 Parameters SETUP=3, PULSE=2, HOLD=4, SETTLE=5: write latency = 11 cycles and read latency = 7 cycles.
REQ-048 WDATA and SEL changed mid-write: REG_CLK and D_OUT still reflect the values latched at acceptance.
